// File: rtl/decoder_arbiter.sv
// ---------------------------------------------------------------------------
// decoder_arbiter
//   Four-requester round-robin arbiter driving the enable/address inputs of a
//   structural 2-to-4 decoder. One winner at a time is granted; the grant is
//   held until the owner pulses done or drops its request, then priority
//   rotates past the winner. Every grant is followed by one IDLE cycle.
//
//   Optional feature (macro DECODER_ARB_TIMEOUT_EN): a hold counter forces a
//   release after HOLD_MAX grant cycles and pulses timeout for one cycle.
//   Without the macro no counter exists and timeout is tied to 0.
//
// Parameters:
//   HOLD_MAX   maximum consecutive grant cycles (timeout build only)
//   CNT_WIDTH  width of the hold counter
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-high reset
//   req[3:0]  in   level-sensitive request lines, bit i = requester i
//   done      in   release strobe from the current owner (GRANT only)
//   address0  out  decoder address LSB (registered)
//   address1  out  decoder address MSB (registered)
//   enable    out  decoder enable, high exactly while in GRANT
//   grant     out  one-hot of {address1,address0} while enable, else 0
//   busy      out  same as enable
//   timeout   out  one-cycle pulse on a forced release
// ---------------------------------------------------------------------------
module decoder_arbiter #(
  parameter int HOLD_MAX  = 15,
  parameter int CNT_WIDTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       done,
  output logic       address0,
  output logic       address1,
  output logic       enable,
  output logic [3:0] grant,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] ptr_q,   ptr_d;

  logic       found;
  logic [1:0] winner;
  logic [1:0] idx;
  logic       hold_expired;
  logic       forced_release;

  // Round-robin search: first set request starting at ptr_q, wrapping mod 4.
  always_comb begin
    found  = 1'b0;
    winner = ptr_q;
    idx    = '0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Next-state logic. A voluntary release (done or dropped request) wins
  // over an expiring hold counter, so a coinciding timeout is suppressed.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    ptr_d          = ptr_q;
    forced_release = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          owner_d = winner;
          ptr_d   = winner + 2'd1;
        end
      end
      GRANT: begin
        if (done || !req[owner_q]) begin
          state_d = IDLE;
        end else if (hold_expired) begin
          state_d        = IDLE;
          forced_release = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef DECODER_ARB_TIMEOUT_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 timeout_q;

  // Every GRANT entry comes from IDLE, so clearing while idle gives a zero
  // count in the first grant cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign hold_expired = (cnt_q == CNT_WIDTH'(HOLD_MAX - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= forced_release;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_cfg;

  assign hold_expired = 1'b0;
  assign timeout      = 1'b0;
  assign unused_cfg   = forced_release ^ (HOLD_MAX > CNT_WIDTH);
`endif

  // Outputs come straight from flops (or a decode of flops only).
  assign enable   = (state_q == GRANT);
  assign busy     = enable;
  assign address0 = owner_q[0];
  assign address1 = owner_q[1];

  always_comb begin
    grant = '0;
    if (enable) begin
      grant[owner_q] = 1'b1;
    end
  end

endmodule

// File: tb/tb_decoder_arbiter.sv
module tb_decoder_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic       done;
  logic       address0;
  logic       address1;
  logic       enable;
  logic [3:0] grant;
  logic       busy;
  logic       timeout;

  int vectors;
  int miscompares;

  decoder_arbiter #(
    .HOLD_MAX  (4),
    .CNT_WIDTH (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .done     (done),
    .address0 (address0),
    .address1 (address1),
    .enable   (enable),
    .grant    (grant),
    .busy     (busy),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expect an active grant to requester idx.
  task automatic expect_grant(input string tag, input int idx);
    logic [3:0] oh;
    logic [1:0] a;
    oh = 4'b0001 << idx;
    a  = 2'(idx);
    check({tag, "_en"},    {7'd0, enable},             8'd1);
    check({tag, "_addr"},  {6'd0, address1, address0}, {6'd0, a});
    check({tag, "_grant"}, {4'd0, grant},              {4'd0, oh});
    check({tag, "_busy"},  {7'd0, busy},               8'd1);
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_en"},    {7'd0, enable}, 8'd0);
    check({tag, "_grant"}, {4'd0, grant},  8'd0);
    check({tag, "_busy"},  {7'd0, busy},   8'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    req         = 4'b0000;
    done        = 1'b0;

    // Reset state
    step();
    step();
    expect_idle("rst");
    check("rst_addr", {6'd0, address1, address0}, 8'd0);
    check("rst_tmo",  {7'd0, timeout},            8'd0);

    // Single request after reset release
    reset = 1'b0;
    req   = 4'b0100;
    step();
    expect_grant("single", 2);
    done = 1'b1;
    step();
    expect_idle("single_rel");
    check("single_addr_keep", {6'd0, address1, address0}, 8'd2);
    done = 1'b0;
    req  = 4'b0000;

    // done in IDLE is ignored
    done = 1'b1;
    step();
    expect_idle("idle_done");
    done = 1'b0;

    // Fresh reset so rotation starts at ptr=0
    reset = 1'b1;
    #2;
    reset = 1'b0;
    step();

    // Round-robin rotation with all requesting: 0,1,2,3,0
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      expect_grant($sformatf("rr%0d", i), i % 4);
      done = 1'b1;
      step();
      expect_idle($sformatf("rr%0d_bubble", i));
      done = 1'b0;
      if (i == 4) req = 4'b0010;
    end

    // ptr=1, only requester 1 asks
    step();
    expect_grant("skip1", 1);
    done = 1'b1;
    step();
    done = 1'b0;
    req  = 4'b1001;
    // ptr=2, search 2,3 -> 3
    step();
    expect_grant("skip3", 3);
    done = 1'b1;
    step();
    expect_idle("skip3_rel");
    done = 1'b0;
    // ptr wrapped to 0 -> requester 0
    step();
    expect_grant("wrap0", 0);
    done = 1'b1;
    step();
    done = 1'b0;
    req  = 4'b0100;

    // Implicit release by dropping the request
    step();
    expect_grant("impl", 2);
    req = 4'b0000;
    step();
    expect_idle("impl_rel");
    req = 4'b0100;
    step();
    expect_grant("regrant", 2);

    // Asynchronous reset in mid-cycle
    #3;
    reset = 1'b1;
    #1;
    expect_idle("async_rst");
    check("async_rst_tmo", {7'd0, timeout}, 8'd0);
    #1;
    reset = 1'b0;
    req   = 4'b1111;
    step();
    expect_grant("ptr_after_rst", 0);
    done = 1'b1;
    step();
    done = 1'b0;
    req  = 4'b0000;
    step();

`ifdef DECODER_ARB_TIMEOUT_EN
    // Forced release after HOLD_MAX=4 cycles
    req = 4'b0001;
    step();
    expect_grant("tmo_c1", 0);
    check("tmo_c1_pulse", {7'd0, timeout}, 8'd0);
    for (int c = 2; c <= 4; c++) begin
      step();
      expect_grant($sformatf("tmo_c%0d", c), 0);
      check($sformatf("tmo_c%0d_pulse", c), {7'd0, timeout}, 8'd0);
    end
    step();
    expect_idle("tmo_forced");
    check("tmo_pulse", {7'd0, timeout}, 8'd1);
    step();
    expect_grant("tmo_regrant", 0);
    check("tmo_pulse_end", {7'd0, timeout}, 8'd0);
    // done in cycle 4 wins over the timeout
    step();
    step();
    step();
    expect_grant("tmo_done_c4", 0);
    done = 1'b1;
    step();
    expect_idle("tmo_done_rel");
    check("tmo_done_pulse", {7'd0, timeout}, 8'd0);
    done = 1'b0;
    req  = 4'b0000;
    step();
`else
    // Without the timeout, a grant persists indefinitely
    req = 4'b0001;
    step();
    for (int c = 0; c < 100; c++) begin
      check($sformatf("hold%0d_en", c),  {7'd0, enable},  8'd1);
      check($sformatf("hold%0d_tmo", c), {7'd0, timeout}, 8'd0);
      step();
    end
    req = 4'b0000;
    step();
    expect_idle("hold_rel");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decoder_arbiter.md
# decoder_arbiter

Four-requester round-robin arbiter that owns the enable and address inputs of the structural 2-to-4 decoder. Requesters 0-3 compete for the decoded select lines; the arbiter picks one winner, drives `{address1,address0}` with its index and raises `enable`, holds the grant until the owner releases, then rotates priority. It sits directly in front of the decoder, and `grant` mirrors the decoder's one-hot outputs for local checking.

## Interface
Parameters:
- `HOLD_MAX`, default 15: maximum consecutive grant cycles before a forced release. Used only with `DECODER_ARB_TIMEOUT_EN`. Legal range 1 to 2^`CNT_WIDTH`-1.
- `CNT_WIDTH`, default 4: width of the hold counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `req`  in  4  request lines; bit i belongs to requester i; level-sensitive.
- `done`  in  1  release strobe from the current owner; sampled only in GRANT.
- `address0`  out  1  decoder address LSB (registered).
- `address1`  out  1  decoder address MSB (registered).
- `enable`  out  1  decoder enable (registered); high exactly while in GRANT.
- `grant`  out  4  one-hot of `{address1,address0}` when `enable`=1, else 0; combinational from registers only.
- `busy`  out  1  equals `enable`.
- `timeout`  out  1  one-cycle pulse on forced release; constant 0 without the macro.

## Operation
- State machine with two states: IDLE and GRANT. Registers: `state`, 2-bit owner index, 2-bit priority pointer `ptr`, and the hold counter (macro only).
- IDLE:
  - If `req`=0, stay in IDLE.
  - Otherwise pick the first set bit in search order `ptr`, `ptr`+1, `ptr`+2, `ptr`+3 (mod 4).
  - Next edge: load the winner into the address outputs, set `enable`=1, go to GRANT, set `ptr` = winner+1 mod 4 (wraps 3 to 0).
- GRANT releases on either condition:
  - `done`=1, or
  - `req[owner]`=0.
  - On release, the next edge returns to IDLE with `enable`=0. `address0`/`address1` keep their last value and are don't-care to the decoder.
  - Otherwise stay in GRANT. Changes on other `req` bits have no effect during GRANT.
- `done` in IDLE is ignored.
- If `done` and a timeout coincide, treat the release as a normal `done`; `timeout` stays 0.
- Reset, including mid-grant: `state`=IDLE, `ptr`=0, owner=0, `address0`=`address1`=0, `enable`=0, `grant`=0, `busy`=0, `timeout`=0, counter=0.

## Timing
- Grant latency: a request sampled at IDLE edge k produces `enable`=1 and a valid address after edge k. The decoder output is valid in the cycle after that edge.
- Release latency: `done` sampled at edge m produces `enable`=0 after edge m.
- Every grant is followed by at least one IDLE cycle, so back-to-back grants are separated by one bubble cycle.
- `grant`, `busy` and `enable` never glitch; they derive only from flops.
- Asynchronous reset deasserts `enable` without waiting for `clk`. Release from reset takes effect at the first clock edge after `reset` falls.

## Configuration
- `DECODER_ARB_TIMEOUT_EN` defined:
  - The hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When it reaches `HOLD_MAX`-1 with no release, the next edge forces IDLE and `timeout`=1 for exactly that following IDLE cycle.
  - The owner therefore holds `enable` for at most `HOLD_MAX` cycles.
  - `ptr` has already advanced, so a still-requesting owner goes to lowest priority.
- `DECODER_ARB_TIMEOUT_EN` not defined:
  - No counter is instantiated.
  - `timeout` is tied to 0.
  - A grant lasts until `done` or the owner's request drops.

## Test plan
- Reset then single request: `reset` 1 to 0, `req`=4'b0100 → after the next edge, `enable`=1, `{address1,address0}`=2'b10, `grant`=4'b0100; then `done`=1 → `enable`=0 one edge later.
- Round-robin rotation: `req`=4'b1111 held, `done` pulsed once per grant → owners 0,1,2,3,0 in order, each separated by one cycle with `enable`=0.
- Pointer skip and wrap: after owner 3 (`ptr`=0), `req`=4'b0010 → owner 1. Then `req`=4'b1001 with `ptr`=2 → owner 3, then `ptr` wraps to 0.
- Implicit release and async reset: while owner 2 is granted, clear `req[2]` → IDLE next edge. Regrant owner 2, then assert `reset` mid-cycle → `enable`, `grant` and `busy` go to 0 before the next `clk` edge, and `ptr`=0.
- Timeout (macro on, `HOLD_MAX`=4): `req`=4'b0001 held, no `done` → `enable` high for exactly 4 cycles, then `timeout`=1 for 1 cycle alongside `enable`=0, then regrant to owner 0. Same stimulus with `done` in cycle 4 → `timeout` stays 0.
- Macro off: `req`=4'b0001 held for 100 cycles without `done` → `enable` stays 1 throughout and `timeout` stays 0.
